// File: rtl/cpu_exc_pkg.sv
// Shared types and constants for the CP0 exception request controller.
// State encoding, exception cause codes and redirect target selects.
package cpu_exc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTER   = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } exc_state_e;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;

    localparam logic REDIR_HANDLER = 1'b0;
    localparam logic REDIR_EPC     = 1'b1;

endpackage

// File: rtl/sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous level inputs.
// Both stages clear on the asynchronous active-low reset.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/exc_req_ctrl.sv
// Initiator side of the CP0 exception interface: picks interrupts/syscalls at
// commit, pulses exl_set/exl_clear, and sequences flush plus PC redirect.
//
// state   | meaning
// IDLE    | normal execution, exceptions taken at commit boundary
// ENTER   | one-cycle flush and redirect to CP0 handler_PC
// HANDLER | handler running, waits for eret (no nesting)
// RETURN  | one-cycle flush and redirect to CP0 EPC
import cpu_exc_pkg::*;

module exc_req_ctrl #(
    parameter int NUM_IRQ  = 6,
    parameter int IRQ_ID_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic                irq_en_we,
    input  logic [NUM_IRQ-1:0]  irq_en_wdata,
    input  logic                commit_valid,
    input  logic [31:0]         commit_pc,
    input  logic                commit_syscall,
    input  logic                commit_eret,
    output logic                exl_set,
    output logic                exl_clear,
    output logic [31:0]         exc_pc,
    output logic                pc_redirect,
    output logic                redirect_sel,
    output logic                flush,
    output logic                in_handler,
    output logic [4:0]          cause_code,
    output logic [IRQ_ID_W-1:0] irq_id,
    output logic [NUM_IRQ-1:0]  irq_en
);

    exc_state_e          state_q;
    exc_state_e          state_d;
    logic [NUM_IRQ-1:0]  sync_irq;
    logic [NUM_IRQ-1:0]  pending;
    logic [IRQ_ID_W-1:0] win_id;
    logic                take;
    logic                sel_q;

    sync2 #(.W(NUM_IRQ)) u_irq_sync (
        .clk (clk),
        .rst (rst),
        .d   (irq),
        .q   (sync_irq)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_en <= '0;
        end else if (irq_en_we) begin
            irq_en <= irq_en_wdata;
        end
    end

    assign pending = sync_irq & irq_en;

    // Scan from the top down so the lowest pending index wins.
    always_comb begin
        win_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                win_id = IRQ_ID_W'(i);
            end
        end
    end

    assign take = commit_valid && (commit_syscall || (pending != '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        exl_set     = 1'b0;
        exl_clear   = 1'b0;
        exc_pc      = '0;
        pc_redirect = 1'b0;
        flush       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    exl_set = 1'b1;
                    exc_pc  = commit_pc;
                    state_d = ST_ENTER;
                end
            end
            ST_ENTER: begin
                pc_redirect = 1'b1;
                flush       = 1'b1;
                state_d     = ST_HANDLER;
            end
            ST_HANDLER: begin
                if (commit_valid && commit_eret) begin
                    exl_clear = 1'b1;
                    state_d   = ST_RETURN;
                end
            end
            ST_RETURN: begin
                pc_redirect = 1'b1;
                flush       = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cause_code <= EXC_INT;
            irq_id     <= '0;
        end else if (state_q == ST_IDLE && take) begin
            if (commit_syscall) begin
                cause_code <= EXC_SYS;
            end else begin
                cause_code <= EXC_INT;
                irq_id     <= win_id;
            end
        end
    end

    // Select is driven directly during the redirect cycles and remembered after.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q <= REDIR_HANDLER;
        end else if (state_q == ST_ENTER) begin
            sel_q <= REDIR_HANDLER;
        end else if (state_q == ST_RETURN) begin
            sel_q <= REDIR_EPC;
        end
    end

    assign redirect_sel = (state_q == ST_ENTER)  ? REDIR_HANDLER :
                          (state_q == ST_RETURN) ? REDIR_EPC     : sel_q;

    assign in_handler = (state_q == ST_HANDLER);

endmodule

// File: tb/tb_exc_req_ctrl.sv
// Self-checking bench for exc_req_ctrl: directed scenarios plus random traffic,
// compared every cycle against a behavioural EXL/redirect model.
module tb_exc_req_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  irq;
    logic        irq_en_we;
    logic [5:0]  irq_en_wdata;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        commit_syscall;
    logic        commit_eret;
    logic        exl_set;
    logic        exl_clear;
    logic [31:0] exc_pc;
    logic        pc_redirect;
    logic        redirect_sel;
    logic        flush;
    logic        in_handler;
    logic [4:0]  cause_code;
    logic [2:0]  irq_id;
    logic [5:0]  irq_en;

    int total = 0;
    int bad   = 0;

    // model: EXL bit, pending redirect kind (0 none, 1 handler, 2 epc), delayed irq view
    logic [5:0] m_s1, m_s2, m_mask;
    logic       m_exl;
    int         m_redir;
    logic [4:0] m_cause;
    logic [2:0] m_id;
    logic       m_sel;

    exc_req_ctrl #(.NUM_IRQ(6), .IRQ_ID_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .irq            (irq),
        .irq_en_we      (irq_en_we),
        .irq_en_wdata   (irq_en_wdata),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .commit_syscall (commit_syscall),
        .commit_eret    (commit_eret),
        .exl_set        (exl_set),
        .exl_clear      (exl_clear),
        .exc_pc         (exc_pc),
        .pc_redirect    (pc_redirect),
        .redirect_sel   (redirect_sel),
        .flush          (flush),
        .in_handler     (in_handler),
        .cause_code     (cause_code),
        .irq_id         (irq_id),
        .irq_en         (irq_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_mask = '0; m_exl = 1'b0; m_redir = 0;
        m_cause = 5'd0; m_id = 3'd0; m_sel = 1'b0;
    endtask

    task automatic drive(input logic cv, input logic [31:0] pc, input logic sys, input logic er);
        commit_valid = cv; commit_pc = pc; commit_syscall = sys; commit_eret = er;
    endtask

    // One cycle: check outputs at the falling edge, advance the model, then cross the rising edge.
    task automatic step();
        logic [5:0] pend;
        logic [2:0] low;
        logic       take, clr, quiet;
        @(negedge clk);
        pend = m_s2 & m_mask;
        low  = 3'd0;
        for (int i = 5; i >= 0; i--) if (pend[i]) low = 3'(i);
        quiet = !m_exl && m_redir == 0;
        take  = rst && quiet && commit_valid && (commit_syscall || pend != 6'd0);
        clr   = rst && m_exl && m_redir == 0 && commit_valid && commit_eret;
        chk("exl_set", 32'(exl_set), 32'(take));
        chk("exl_clear", 32'(exl_clear), 32'(clr));
        chk("exc_pc", exc_pc, take ? commit_pc : 32'd0);
        chk("pc_redirect", 32'(pc_redirect), 32'(m_redir != 0));
        chk("flush", 32'(flush), 32'(m_redir != 0));
        chk("redirect_sel", 32'(redirect_sel),
            32'((m_redir == 1) ? 1'b0 : (m_redir == 2) ? 1'b1 : m_sel));
        chk("in_handler", 32'(in_handler), 32'(m_exl && m_redir == 0));
        chk("cause_code", 32'(cause_code), 32'(m_cause));
        chk("irq_id", 32'(irq_id), 32'(m_id));
        chk("irq_en", 32'(irq_en), 32'(m_mask));
        if (!rst) begin
            model_reset();
        end else begin
            if (m_redir == 1) m_sel = 1'b0;
            if (m_redir == 2) m_sel = 1'b1;
            m_redir = take ? 1 : (clr ? 2 : 0);
            if (take) begin
                m_exl = 1'b1;
                m_cause = commit_syscall ? 5'd8 : 5'd0;
                if (!commit_syscall) m_id = low;
            end
            if (clr) m_exl = 1'b0;
            m_s2 = m_s1;
            m_s1 = irq;
            if (irq_en_we) m_mask = irq_en_wdata;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        rst = 1'b0; irq = 6'h3F; irq_en_we = 1'b0; irq_en_wdata = 6'h00;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b1;
        // mask is zero after reset, so ten commits must not trigger anything
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h40 + 32'(i * 4), 1'b0, 1'b0);
            step();
        end

        // interrupt entry on irq[2]
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        irq = 6'h04; irq_en_we = 1'b1; irq_en_wdata = 6'h04;
        step();
        irq_en_we = 1'b0;
        step();
        step();
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        // eret with irq[2] still up: RETURN-cycle commit ignored, the next one re-enters
        drive(1'b1, 32'h180, 1'b0, 1'b1);
        step();
        drive(1'b1, 32'h104, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h108, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        irq = 6'h00;
        step();
        step();
        drive(1'b1, 32'h184, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step();

        // priority: syscall beats irqs, then lowest irq index wins
        irq_en_we = 1'b1; irq_en_wdata = 6'h3F; irq = 6'b011010;
        step();
        irq_en_we = 1'b0;
        step();
        step();
        drive(1'b1, 32'h200, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        // no nesting: storm of irqs and syscalls in HANDLER
        for (int i = 0; i < 6; i++) begin
            irq = 6'($urandom);
            drive(1'b1, 32'h300 + 32'(i * 4), 1'($urandom), 1'b0);
            step();
        end
        irq = 6'b011010;
        drive(1'b1, 32'h280, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        step();
        drive(1'b1, 32'h204, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        drive(1'b1, 32'h284, 1'b0, 1'b1);
        step();
        // spurious eret in IDLE
        irq = 6'h00;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step();
        drive(1'b1, 32'h400, 1'b0, 1'b1);
        step();
        step();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) irq = 6'($urandom) & 6'($urandom);
            irq_en_we    = ($urandom_range(0, 15) == 0);
            irq_en_wdata = 6'($urandom);
            drive(1'($urandom), $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
            step();
        end
        irq_en_we = 1'b0;

        // reset in the middle of ENTER
        for (int i = 0; i < 10 && (m_exl || m_redir != 0); i++) begin
            drive(1'b1, 32'h500, 1'b0, 1'b1);
            step();
        end
        irq = 6'h3F; irq_en_we = 1'b1; irq_en_wdata = 6'h3F;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        irq_en_we = 1'b0;
        step();
        step();
        drive(1'b1, 32'h600, 1'b0, 1'b0);
        for (int i = 0; i < 20 && m_redir != 1; i++) step();
        chk("enter_reached", 32'(pc_redirect), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_redirect", 32'(pc_redirect), 32'd0);
        chk("rst_mid_flush", 32'(flush), 32'd0);
        chk("rst_mid_sel", 32'(redirect_sel), 32'd0);
        model_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h700 + 32'(i * 4), 1'b0, 1'($urandom));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/exc_req_ctrl.md
Name: exc_req_ctrl

Overview:
- Initiator side of the CP0 exception interface.
- Collects external interrupt lines and syscall exceptions from the commit stage, and picks one at an instruction boundary.
- Issues the exl_set / exl_clear pulses with the PC to save into CP0.
- Sequences the pipeline flush and the PC redirect to CP0's handler_PC on entry and to CP0's EPC on eret.

Parameters:
- NUM_IRQ, 6, number of external interrupt lines.
- IRQ_ID_W, 3, width of the interrupt index; must satisfy 2**IRQ_ID_W >= NUM_IRQ.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset: asserted when 0, released synchronously by design convention.
- irq  input  NUM_IRQ  level-sensitive asynchronous interrupt lines.
- irq_en_we  input  1  write strobe for the interrupt enable mask.
- irq_en_wdata  input  NUM_IRQ  new enable mask value.
- commit_valid  input  1  an instruction is at the commit boundary this cycle.
- commit_pc  input  32  PC of the committing instruction.
- commit_syscall  input  1  committing instruction is syscall; qualified by commit_valid.
- commit_eret  input  1  committing instruction is eret; qualified by commit_valid.
- exl_set  output  1  one-cycle pulse to CP0 to save exc_pc and set EXL.
- exl_clear  output  1  one-cycle pulse to CP0 on eret.
- exc_pc  output  32  PC presented to CP0 with exl_set.
- pc_redirect  output  1  one-cycle pulse: fetch must load the target chosen by redirect_sel.
- redirect_sel  output  1  0 = CP0 handler_PC, 1 = CP0 EPC.
- flush  output  1  squash all younger pipeline stages; high with pc_redirect.
- in_handler  output  1  exception handler is active (mirror of EXL).
- cause_code  output  5  last exception code: 0 = interrupt, 8 = syscall.
- irq_id  output  IRQ_ID_W  index of the last interrupt taken.
- irq_en  output  NUM_IRQ  current enable mask.

Behaviour:
- Reset: all outputs are 0, irq_en = 0, synchronizers are cleared, and the FSM goes to IDLE. Reset mid-operation aborts any sequence immediately; no pulse is emitted after reset.
- Synchronization: each irq bit passes through a 2-flop synchronizer.
  - pending = sync_irq & irq_en.
  - An irq asserted before edge t becomes visible in pending after edge t+1.
- Mask: irq_en_we updates irq_en on the next edge, in any state. A mask write and a take in the same cycle use the old mask.
- Priority: commit_syscall beats interrupts. Among interrupts, the lowest index wins.
- FSM states: IDLE, ENTER, HANDLER, RETURN.
- IDLE, with commit_valid and (commit_syscall or pending != 0):
  - exl_set = 1 (combinational, same cycle) and exc_pc = commit_pc. The committing instruction is squashed: it will be re-executed for an interrupt, or skipped by the handler for a syscall.
  - Latch cause_code (8 for syscall, else 0) and irq_id (winner index; unchanged for syscall) on the edge.
  - Next state ENTER.
- IDLE, commit_eret with no exception: ignored, no pulses.
- Pending without commit_valid: wait; never take an exception mid-bubble.
- ENTER (exactly 1 cycle): pc_redirect = 1, redirect_sel = 0, flush = 1. Next state HANDLER.
- HANDLER:
  - in_handler = 1. Interrupts and syscalls are ignored (no nesting).
  - On commit_valid and commit_eret: exl_clear = 1 (same cycle), next state RETURN.
- RETURN (exactly 1 cycle): pc_redirect = 1, redirect_sel = 1, flush = 1. in_handler drops on entry to RETURN. Next state IDLE.
- Back-to-back: an interrupt still pending in IDLE after RETURN is taken on the next commit_valid. Minimum gap from the exl_clear cycle to the next exl_set is 2 cycles.
- Exclusivity: exl_set and exl_clear are never high in the same cycle.
- redirect_sel: holds its last value outside pulses; only meaningful when pc_redirect = 1.

Decomposition:
- Shared package cpu_exc_pkg:
  - state encoding for IDLE/ENTER/HANDLER/RETURN;
  - EXC_INT = 5'd0 and EXC_SYS = 5'd8;
  - REDIR_HANDLER = 1'b0 and REDIR_EPC = 1'b1.
- One natural sub-module, sync2: a parameterized-width 2-flop synchronizer with the same async active-low rst, instantiated once for irq.
- The priority encoder stays inline.

Test Plan:
- Reset with irq = 6'h3F: all outputs 0, irq_en = 0. After release and 10 commits, exl_set never fires.
- Interrupt entry: irq_en = 6'h04, raise irq[2], commit pc 0x100 with commit_valid.
  - The first commit at least 2 edges after the irq edge gives exl_set = 1 with exc_pc = 0x100.
  - Next cycle: pc_redirect = 1, redirect_sel = 0, flush = 1, then in_handler = 1.
  - cause_code = 0, irq_id = 2.
- Priority: irq_en = 6'h3F, irq = 6'b011010, with commit_syscall at pc 0x200. exl_set fires with cause_code = 8 and exc_pc = 0x200. Repeat without syscall: irq_id = 1.
- eret: in HANDLER, commit_eret gives exl_clear = 1 that cycle. Next cycle: pc_redirect = 1, redirect_sel = 1, flush = 1, then IDLE with in_handler = 0. If irq is still pending, re-entry happens on the second following commit.
- No nesting, spurious eret: in HANDLER, toggle all irqs and syscall → no exl_set. In IDLE, commit_eret → no exl_clear and no redirect.
- Reset mid-sequence: drop rst in ENTER → pc_redirect = 0 immediately and state IDLE. After release, no exl_clear or redirect appears until a new exception is taken.
